// File: rtl/mem_arb.sv
// Shared memory port arbiter for the fetch and data requesters.
// Data normally wins a conflict; fetch wins right after a data grant.
module mem_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_wdata,
  output logic        if_ack,
  output logic        dm_ack,
  output logic        if_err,
  output logic        dm_err,
  output logic [63:0] rdata,
  output logic        if_wait,
  output logic        dm_wait,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  input  logic        mem_err
);

  typedef enum logic [1:0] {
    IDLE,
    IF_BUSY,
    DM_BUSY,
    RESP
  } state_t;

  state_t      state_q;
  logic        last_dm_q;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;
  logic        if_ack_q;
  logic        dm_ack_q;
  logic        if_err_q;
  logic        dm_err_q;
  logic [63:0] rdata_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [63:0] mem_addr_q;
  logic [63:0] mem_wdata_q;
  logic        grant_dm;
  logic        timeout;
  logic        done;

  assign cnt_d    = cnt_q + 4'd1;
  assign timeout  = (cnt_d == 4'd15);
  assign done     = mem_ack | timeout;
  assign grant_dm = dm_req & (~if_req | ~last_dm_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_dm_q   <= 1'b0;
      cnt_q       <= 4'd0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      dm_err_q    <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      if_err_q <= 1'b0;
      dm_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_dm) begin
            state_q     <= DM_BUSY;
            last_dm_q   <= 1'b1;
            cnt_q       <= 4'd0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= dm_we;
            mem_addr_q  <= dm_addr;
            mem_wdata_q <= dm_wdata;
          end else if (if_req) begin
            state_q     <= IF_BUSY;
            last_dm_q   <= 1'b0;
            cnt_q       <= 4'd0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= '0;
          end
        end
        IF_BUSY, DM_BUSY: begin
          if (!mem_ack) cnt_q <= cnt_d;
          if (done) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            // A timeout reports an error with zeroed read data.
            rdata_q   <= mem_ack ? mem_rdata : '0;
            if (state_q == IF_BUSY) begin
              if_ack_q <= 1'b1;
              if_err_q <= ~mem_ack | mem_err;
            end else begin
              dm_ack_q <= 1'b1;
              dm_err_q <= ~mem_ack | mem_err;
            end
          end
        end
        RESP: state_q <= IDLE;
      endcase
    end
  end

  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_err    = if_err_q;
  assign dm_err    = dm_err_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_wait   = if_req & ~if_ack_q;
  assign dm_wait   = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed scenarios plus randomized traffic
// checked against a transaction-level arbitration model.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [63:0] if_addr;
  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic        if_ack;
  logic        dm_ack;
  logic        if_err;
  logic        dm_err;
  logic [63:0] rdata;
  logic        if_wait;
  logic        dm_wait;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        mem_err;

  int n_cmp = 0;
  int n_bad = 0;
  int dual_cnt = 0;
  bit last_dm;

  always #5 clk = ~clk;

  mem_arb dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .if_ack(if_ack), .dm_ack(dm_ack),
    .if_err(if_err), .dm_err(dm_err),
    .rdata(rdata),
    .if_wait(if_wait), .dm_wait(dm_wait),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_err(mem_err)
  );

  always @(negedge clk) if (if_ack && dm_ack) dual_cnt++;

  task automatic idle_inputs();
    if_req  = 1'b0;
    dm_req  = 1'b0;
    mem_ack = 1'b0;
    mem_err = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    last_dm = 1'b0;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < 5);
  endtask

  // Memory responder: acks on busy cycle lat+1; lat >= 15 never acks.
  task automatic serve(input int lat, input logic [63:0] d,
                       input logic e, output int busy,
                       output logic ia, output logic da,
                       output logic ie, output logic de,
                       output logic [63:0] rd, output logic got);
    busy = 0; got = 0;
    ia = 0; da = 0; ie = 0; de = 0; rd = '0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (mem_req) begin
        busy++;
        if (busy == lat + 1) begin
          mem_ack = 1'b1; mem_rdata = d; mem_err = e;
        end
      end
      @(negedge clk);
      mem_ack = 1'b0; mem_err = 1'b0;
      mem_rdata = {$urandom, $urandom};
      if (if_ack || dm_ack) begin
        got = 1; ia = if_ack; da = dm_ack;
        ie = if_err; de = dm_err; rd = rdata;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({mem_req, mem_we, if_ack, dm_ack, if_err, dm_err} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctl got %b want 000000",
               {mem_req, mem_we, if_ack, dm_ack, if_err, dm_err});
    end
    n_cmp++;
    if ((mem_addr | mem_wdata | rdata) !== 64'h0) begin
      n_bad++;
      $display("FAIL reset_data got %h/%h/%h want 0",
               mem_addr, mem_wdata, rdata);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_noreq got %b want 0", mem_req);
    end
  endtask

  task automatic test_fetch_read();
    int n, busy;
    logic ia, da, ie, de, got;
    logic [63:0] rd;
    if_addr = 64'h100;
    if_req  = 1'b1;
    wait_grant(n);
    n_cmp++;
    if (n != 1 || mem_addr !== 64'h100 || mem_we !== 1'b0 || if_wait !== 1'b1) begin
      n_bad++;
      $display("FAIL fetch_grant got n=%0d addr=%h we=%b wait=%b want 1/100/0/1",
               n, mem_addr, mem_we, if_wait);
    end
    serve(0, 64'h30F2_1234_5678_9ABC, 1'b0, busy, ia, da, ie, de, rd, got);
    n_cmp++;
    if (!got || busy != 1 || {ia, da, ie} !== 3'b100 || rd !== 64'h30F2_1234_5678_9ABC) begin
      n_bad++;
      $display("FAIL fetch_ack got busy=%0d ack=%b%b err=%b rd=%h want 1/10/0/30f2123456789abc",
               busy, ia, da, ie, rd);
    end
    if_req  = 1'b0;
    last_dm = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_both();
    int n, busy;
    logic ia, da, ie, de, got;
    logic [63:0] rd;
    if_addr  = 64'h180;
    dm_addr  = 64'h200;
    dm_we    = 1'b1;
    dm_wdata = 64'h55;
    if_req   = 1'b1;
    dm_req   = 1'b1;
    wait_grant(n);
    n_cmp++;
    if (n != 1 || mem_we !== 1'b1 || mem_addr !== 64'h200 || mem_wdata !== 64'h55) begin
      n_bad++;
      $display("FAIL both_first got n=%0d we=%b addr=%h wd=%h want 1/1/200/55",
               n, mem_we, mem_addr, mem_wdata);
    end
    serve(2, 64'h0, 1'b0, busy, ia, da, ie, de, rd, got);
    n_cmp++;
    if (!got || busy != 3 || {ia, da, de} !== 3'b010) begin
      n_bad++;
      $display("FAIL both_dmack got busy=%0d ack=%b%b err=%b want 3/01/0",
               busy, ia, da, de);
    end
    dm_req = 1'b0;
    wait_grant(n);
    n_cmp++;
    if (n != 2 || mem_addr !== 64'h180 || mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL both_second got n=%0d addr=%h we=%b want 2/180/0",
               n, mem_addr, mem_we);
    end
    serve(1, 64'hABCD, 1'b0, busy, ia, da, ie, de, rd, got);
    n_cmp++;
    if (!got || busy != 2 || {ia, da} !== 2'b10 || rd !== 64'hABCD) begin
      n_bad++;
      $display("FAIL both_ifack got busy=%0d ack=%b%b rd=%h want 2/10/abcd",
               busy, ia, da, rd);
    end
    if_req  = 1'b0;
    last_dm = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n, busy, dm_left, if_left;
    logic ia, da, ie, de, got, is_dm;
    logic [63:0] rd;
    logic [4:0] order;
    order = 5'b10101;
    do_reset();
    dm_left = 3; if_left = 2;
    if_addr = 64'h1000;
    dm_addr = 64'h2000;
    dm_we   = 1'b0;
    if_req  = 1'b1;
    dm_req  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(n);
      is_dm = (mem_addr[15:12] == 4'h2);
      n_cmp++;
      if (n != (k == 0 ? 1 : 2) || is_dm !== order[4 - k] || mem_req !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_grant%0d got n=%0d dm=%b want dm=%b",
                 k, n, is_dm, order[4 - k]);
      end
      if (if_left > 0) begin
        n_cmp++;
        if (if_wait !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_ifwait%0d got %b want 1", k, if_wait);
        end
      end
      serve($urandom_range(0, 3), {$urandom, $urandom}, 1'b0,
            busy, ia, da, ie, de, rd, got);
      n_cmp++;
      if (!got || {ia, da} !== {~order[4 - k], order[4 - k]}
          || (ia && if_wait !== 1'b0)) begin
        n_bad++;
        $display("FAIL b2b_ack%0d got ack=%b%b wait=%b want %b%b",
                 k, ia, da, if_wait, ~order[4 - k], order[4 - k]);
      end
      if (da) begin
        dm_left--;
        dm_addr = dm_addr + 64'h8;
        if (dm_left == 0) dm_req = 1'b0;
      end
      if (ia) begin
        if_left--;
        if_addr = if_addr + 64'h4;
        if (if_left == 0) if_req = 1'b0;
      end
    end
    last_dm = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int n, busy;
    logic ia, da, ie, de, got;
    logic [63:0] rd;
    dm_addr = 64'h300;
    dm_we   = 1'b0;
    dm_req  = 1'b1;
    wait_grant(n);
    serve(99, 64'h0, 1'b0, busy, ia, da, ie, de, rd, got);
    n_cmp++;
    if (!got || busy != 15 || {ia, da, de} !== 3'b011 || rd !== 64'h0
        || mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout got busy=%0d ack=%b%b err=%b rd=%h mreq=%b want 15/01/1/0/0",
               busy, ia, da, de, rd, mem_req);
    end
    dm_req  = 1'b0;
    last_dm = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_err_stray();
    int n, busy;
    logic ia, da, ie, de, got;
    logic [63:0] rd;
    if_addr = 64'h440;
    if_req  = 1'b1;
    wait_grant(n);
    serve(0, 64'h77, 1'b1, busy, ia, da, ie, de, rd, got);
    n_cmp++;
    if (!got || {ia, da, ie} !== 3'b101) begin
      n_bad++;
      $display("FAIL memerr got ack=%b%b err=%b want 10/1", ia, da, ie);
    end
    if_req  = 1'b0;
    last_dm = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({if_ack, dm_ack, mem_req} !== 3'b000) begin
      n_bad++;
      $display("FAIL stray_ack got %b want 000", {if_ack, dm_ack, mem_req});
    end
  endtask

  task automatic test_reset_mid();
    int n, busy;
    logic ia, da, ie, de, got;
    logic [63:0] rd;
    dm_addr  = 64'h400;
    dm_we    = 1'b1;
    dm_wdata = 64'hCAFE;
    dm_req   = 1'b1;
    wait_grant(n);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({mem_req, mem_we, dm_ack} !== 3'b000 || mem_addr !== 64'h0) begin
      n_bad++;
      $display("FAIL midreset got req=%b we=%b ack=%b addr=%h want 0/0/0/0",
               mem_req, mem_we, dm_ack, mem_addr);
    end
    reset   = 1'b0;
    last_dm = 1'b0;
    wait_grant(n);
    n_cmp++;
    if (n != 1 || mem_addr !== 64'h400 || mem_we !== 1'b1 || mem_wdata !== 64'hCAFE) begin
      n_bad++;
      $display("FAIL regrant got n=%0d addr=%h we=%b wd=%h want 1/400/1/cafe",
               n, mem_addr, mem_we, mem_wdata);
    end
    serve(0, 64'h0, 1'b0, busy, ia, da, ie, de, rd, got);
    n_cmp++;
    if (!got || {ia, da, de} !== 3'b010) begin
      n_bad++;
      $display("FAIL regrant_ack got ack=%b%b err=%b want 01/0", ia, da, de);
    end
    dm_req  = 1'b0;
    last_dm = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    int n, busy, lat, exp_busy, r;
    logic ia, da, ie, de, got, e, exp_dm, exp_err, first, pend_if, pend_dm;
    logic [63:0] rd, d, exp_rd;
    do_reset();
    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(1, 3);
      pend_if  = r[0];
      pend_dm  = r[1];
      if_addr  = {$urandom, $urandom};
      dm_addr  = {$urandom, $urandom};
      dm_wdata = {$urandom, $urandom};
      dm_we    = $urandom_range(0, 1) == 1;
      if_req   = pend_if;
      dm_req   = pend_dm;
      first    = 1'b1;
      while (pend_if || pend_dm) begin
        wait_grant(n);
        // Data wins a conflict unless the previous grant went to data.
        exp_dm = pend_dm && !(pend_if && last_dm);
        n_cmp++;
        if (n != (first ? 1 : 2) || mem_req !== 1'b1
            || mem_addr !== (exp_dm ? dm_addr : if_addr)
            || mem_we !== (exp_dm ? dm_we : 1'b0)
            || (exp_dm && dm_we && mem_wdata !== dm_wdata)) begin
          n_bad++;
          $display("FAIL rnd_grant%0d got n=%0d addr=%h we=%b want dm=%b",
                   it, n, mem_addr, mem_we, exp_dm);
        end
        first = 1'b0;
        lat = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 4);
        e   = $urandom_range(0, 3) == 0;
        d   = {$urandom, $urandom};
        serve(lat, d, e, busy, ia, da, ie, de, rd, got);
        exp_busy = (lat >= 15) ? 15 : lat + 1;
        exp_err  = (lat >= 15) || e;
        exp_rd   = (lat >= 15) ? 64'h0 : d;
        n_cmp++;
        if (!got || busy != exp_busy || {ia, da} !== {~exp_dm, exp_dm}
            || (exp_dm ? de : ie) !== exp_err
            || ((!exp_dm || !dm_we || lat >= 15) && rd !== exp_rd)) begin
          n_bad++;
          $display("FAIL rnd_ack%0d got busy=%0d ack=%b%b err=%b%b rd=%h want busy=%0d dm=%b err=%b rd=%h",
                   it, busy, ia, da, ie, de, rd, exp_busy, exp_dm, exp_err, exp_rd);
        end
        last_dm = exp_dm;
        if (exp_dm) begin pend_dm = 1'b0; dm_req = 1'b0; end
        else begin pend_if = 1'b0; if_req = 1'b0; end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset     = 1'b1;
    if_addr   = '0;
    dm_addr   = '0;
    dm_wdata  = '0;
    dm_we     = 1'b0;
    mem_rdata = '0;
    idle_inputs();
    test_reset();
    test_fetch_read();
    test_both();
    test_back_to_back();
    test_timeout();
    test_err_stray();
    test_reset_mid();
    test_random();
    n_cmp++;
    if (dual_cnt != 0) begin
      n_bad++;
      $display("FAIL dual_ack got %0d want 0", dual_cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
